// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw button levels and the game enable going in,
// the conditioned play, its strobes and the debug state coming out.
interface condicionador_botoes_if;
    logic [3:0] botoes_raw;
    logic       habilita;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    // Side that drives the buttons and consumes the conditioned play.
    modport master (
        output botoes_raw,
        output habilita,
        input  jogada,
        input  tem_jogada,
        input  jogada_invalida,
        input  db_estado
    );

    // Conditioner side.
    modport slave (
        input  botoes_raw,
        input  habilita,
        output jogada,
        output tem_jogada,
        output jogada_invalida,
        output db_estado
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Button conditioner: two-stage synchroniser, debounce filter, multi-press
// rejection and release-before-next-press, producing a one-hot play with a
// single-cycle strobe per physical press. All outputs come straight from flops.
module condicionador_botoes #(
    parameter int DEBOUNCE = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    condicionador_botoes_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        ESPERA   = 3'b000,
        FILTRA   = 3'b001,
        ACEITA   = 3'b010,
        INVALIDA = 3'b011,
        SOLTA    = 3'b100
    } estado_t;

    // True when exactly one button bit is set.
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    logic [3:0]    s1_q, s2_q;
    logic [3:0]    sample_q, sample_d;
    logic [CW-1:0] cnt_q, cnt_d;
    estado_t       state_q, state_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          tem_jogada_q, tem_jogada_d;
    logic          invalida_q, invalida_d;

    // Two-flop synchroniser; only s2_q is ever looked at by the FSM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
        end else begin
            s1_q <= bus.botoes_raw;
            s2_q <= s1_q;
        end
    end

    // Next-state logic: debounce counting, the accept/reject decision and release wait.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        jogada_d = jogada_q;
        case (state_q)
            ESPERA: begin
                if (s2_q != 4'b0000) begin
                    sample_d = s2_q;
                    cnt_d    = CNT_ZERO;
                    state_d  = FILTRA;
                end else begin
                    state_d  = ESPERA;
                end
            end
            FILTRA: begin
                if (s2_q == 4'b0000) begin
                    state_d = ESPERA;
                end else if (s2_q != sample_q) begin
                    // Pattern changed mid-filter: restart stability count on the new one.
                    sample_d = s2_q;
                    cnt_d    = CNT_ZERO;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // Stable long enough: decide. The release wait always starts from zero.
                    cnt_d = CNT_ZERO;
                    if (!is_one_hot(sample_q)) begin
                        state_d = INVALIDA;
                    end else if (bus.habilita) begin
                        state_d  = ACEITA;
                        jogada_d = sample_q;
                    end else begin
                        state_d = SOLTA;
                    end
                end
            end
            ACEITA: begin
                state_d = SOLTA;
                cnt_d   = CNT_ZERO;
            end
            INVALIDA: begin
                state_d = SOLTA;
                cnt_d   = CNT_ZERO;
            end
            SOLTA: begin
                if (s2_q != 4'b0000) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ESPERA;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Strobes are derived from the next state so they are registered alongside it.
    always_comb begin
        tem_jogada_d = (state_d == ACEITA);
        invalida_d   = (state_d == INVALIDA);
    end

    // FSM state and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ESPERA;
            sample_q     <= 4'b0000;
            cnt_q        <= CNT_ZERO;
            jogada_q     <= 4'b0000;
            tem_jogada_q <= 1'b0;
            invalida_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            cnt_q        <= cnt_d;
            jogada_q     <= jogada_d;
            tem_jogada_q <= tem_jogada_d;
            invalida_q   <= invalida_d;
        end
    end

    assign bus.jogada          = jogada_q;
    assign bus.tem_jogada      = tem_jogada_q;
    assign bus.jogada_invalida = invalida_q;
    assign bus.db_estado       = state_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus random button
// activity, compared each cycle against a run-length model of the filter.
module tb_condicionador_botoes;

    localparam int DEB = 3;

    logic clock;
    logic reset;
    condicionador_botoes_if bus();

    condicionador_botoes #(.DEBOUNCE(DEB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int obs_tem = 0;
    int obs_inv = 0;
    int cyc = 0;

    // Reference model: counts how long a nonzero pattern has been seen,
    // and after a decision how long the buttons have been released.
    logic [3:0] m_s1, m_s2, m_pat, m_jog;
    int         m_run, m_zrun;
    bit         m_armed, m_skip, m_tem, m_inv;

    task automatic model_step();
        logic [3:0] in_v;
        if (!reset) begin
            m_s1 = 4'b0000; m_s2 = 4'b0000; m_pat = 4'b0000; m_jog = 4'b0000;
            m_run = 0; m_zrun = 0; m_armed = 1'b1; m_skip = 1'b0;
            m_tem = 1'b0; m_inv = 1'b0;
        end else begin
            in_v  = m_s2;
            m_tem = 1'b0;
            m_inv = 1'b0;
            if (m_armed) begin
                if (in_v == 4'b0000) m_run = 0;
                else if (m_run != 0 && in_v == m_pat) m_run++;
                else begin m_pat = in_v; m_run = 1; end
                if (m_run == DEB + 1) begin
                    m_run = 0; m_zrun = 0; m_armed = 1'b0;
                    if ($countones(m_pat) > 1) begin m_inv = 1'b1; m_skip = 1'b1; end
                    else if (bus.habilita) begin m_tem = 1'b1; m_jog = m_pat; m_skip = 1'b1; end
                    else m_skip = 1'b0;
                end
            end else if (m_skip) begin
                m_skip = 1'b0;
            end else if (in_v != 4'b0000) begin
                m_zrun = 0;
            end else begin
                m_zrun++;
                if (m_zrun == DEB) m_armed = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = bus.botoes_raw;
        end
    endtask

    function automatic logic [2:0] exp_estado();
        if (m_tem) return 3'b010;
        if (m_inv) return 3'b011;
        if (!m_armed) return 3'b100;
        if (m_run == 0) return 3'b000;
        return 3'b001;
    endfunction

    function automatic logic [8:0] dut_vec();
        return {bus.jogada, bus.tem_jogada, bus.jogada_invalida, bus.db_estado};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_jog, m_tem, m_inv, exp_estado()};
    endfunction

    // One clock: model sees the same inputs as the DUT edge; outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        cyc++;
        if (bus.tem_jogada) obs_tem++;
        if (bus.jogada_invalida) obs_inv++;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.botoes_raw = 4'b0000; bus.habilita = 1'b0;
        cycle();
        checks++;
        if (dut_vec() !== 9'b0) begin
            errors++;
            $display("FAIL reset: got %b required %b", dut_vec(), 9'b0);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_press();
        obs_tem = 0;
        bus.habilita = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.botoes_raw = (i < 5) ? 4'b0001 : 4'b0000;
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_press i=%0d: got %b required %b", i, dut_vec(), exp_vec());
            end
            if (i == 5) begin
                checks++;
                if (bus.tem_jogada !== 1'b1 || bus.jogada !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_press_latency: got tem=%b jogada=%b required 1 0001", bus.tem_jogada, bus.jogada);
                end
            end
            if (i == 9) begin
                checks++;
                if (bus.db_estado !== 3'b000) begin
                    errors++;
                    $display("FAIL single_press_release: got %b required 000", bus.db_estado);
                end
            end
        end
        checks++;
        if (obs_tem != 1 || bus.jogada !== 4'b0001) begin
            errors++;
            $display("FAIL single_press_count: got pulses=%0d jogada=%b required 1 0001", obs_tem, bus.jogada);
        end
    endtask

    task automatic test_bounce();
        obs_tem = 0;
        for (int i = 0; i < 8; i++) begin
            bus.botoes_raw = (i < 2) ? 4'b0010 : 4'b0000;
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce i=%0d: got %b required %b", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_tem != 0 || bus.jogada !== 4'b0001 || bus.db_estado !== 3'b000) begin
            errors++;
            $display("FAIL bounce_result: got pulses=%0d jogada=%b estado=%b required 0 0001 000",
                     obs_tem, bus.jogada, bus.db_estado);
        end
    endtask

    task automatic test_invalid();
        obs_tem = 0; obs_inv = 0;
        for (int i = 0; i < 12; i++) begin
            bus.botoes_raw = (i < 5) ? 4'b0101 : 4'b0000;
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL invalid i=%0d: got %b required %b", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (obs_inv != 1 || obs_tem != 0 || bus.jogada !== 4'b0001) begin
            errors++;
            $display("FAIL invalid_result: got inv=%0d tem=%0d jogada=%b required 1 0 0001",
                     obs_inv, obs_tem, bus.jogada);
        end
    endtask

    task automatic test_long_press();
        obs_tem = 0;
        for (int i = 0; i < 320; i++) begin
            if (i < 300) bus.botoes_raw = 4'b1000;
            else if (i < 306) bus.botoes_raw = 4'b0000;
            else if (i < 311) bus.botoes_raw = 4'b0100;
            else bus.botoes_raw = 4'b0000;
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long_press i=%0d: got %b required %b", i, dut_vec(), exp_vec());
            end
            if (i == 299) begin
                checks++;
                if (obs_tem != 1 || bus.jogada !== 4'b1000) begin
                    errors++;
                    $display("FAIL long_press_hold: got pulses=%0d jogada=%b required 1 1000", obs_tem, bus.jogada);
                end
            end
        end
        checks++;
        if (obs_tem != 2 || bus.jogada !== 4'b0100) begin
            errors++;
            $display("FAIL long_press_next: got pulses=%0d jogada=%b required 2 0100", obs_tem, bus.jogada);
        end
    endtask

    task automatic test_habilita_late();
        obs_tem = 0;
        bus.habilita = 1'b0;
        for (int i = 0; i < 47; i++) begin
            bus.habilita   = (i >= 10) ? 1'b1 : 1'b0;
            bus.botoes_raw = (i < 30 || (i >= 36 && i < 41)) ? 4'b0010 : 4'b0000;
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL habilita i=%0d: got %b required %b", i, dut_vec(), exp_vec());
            end
            if (i == 29) begin
                checks++;
                if (obs_tem != 0 || bus.jogada !== 4'b0100) begin
                    errors++;
                    $display("FAIL habilita_held: got pulses=%0d jogada=%b required 0 0100", obs_tem, bus.jogada);
                end
            end
        end
        checks++;
        if (obs_tem != 1 || bus.jogada !== 4'b0010) begin
            errors++;
            $display("FAIL habilita_repress: got pulses=%0d jogada=%b required 1 0010", obs_tem, bus.jogada);
        end
    endtask

    task automatic test_reset_mid_filter();
        obs_tem = 0;
        bus.habilita = 1'b1;
        bus.botoes_raw = 4'b0001;
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (bus.db_estado !== 3'b001) begin
            errors++;
            $display("FAIL midfilter_state: got %b required 001", bus.db_estado);
        end
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        bus.botoes_raw = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== 9'b0 || exp_vec() !== 9'b0) begin
                errors++;
                $display("FAIL midfilter_reset i=%0d: got %b required %b", i, dut_vec(), 9'b0);
            end
        end
        checks++;
        if (obs_tem != 0) begin
            errors++;
            $display("FAIL midfilter_pulses: got %0d required 0", obs_tem);
        end
    endtask

    task automatic test_random();
        logic [3:0] pat;
        int         len;
        logic       prev_t, prev_i;
        prev_t = 1'b0; prev_i = 1'b0;
        for (int s = 0; s < 300; s++) begin
            case ($urandom_range(0, 3))
                0:       pat = 4'b0000;
                1:       pat = 4'($urandom_range(1, 15));
                default: pat = 4'b0001 << 2'($urandom_range(0, 3));
            endcase
            len = $urandom_range(1, 7);
            bus.habilita = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                bus.botoes_raw = pat;
                cycle();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random seg=%0d i=%0d: got %b required %b", s, i, dut_vec(), exp_vec());
                end
                checks++;
                if ((bus.tem_jogada && bus.jogada_invalida) || (bus.tem_jogada && prev_t) ||
                    (bus.jogada_invalida && prev_i)) begin
                    errors++;
                    $display("FAIL random_strobes seg=%0d: got tem=%b inv=%b prev=%b%b required non-overlapping single pulses",
                             s, bus.tem_jogada, bus.jogada_invalida, prev_t, prev_i);
                end
                prev_t = bus.tem_jogada;
                prev_i = bus.jogada_invalida;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.botoes_raw = 4'b0000;
        bus.habilita = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_invalid();
        test_long_press();
        test_habilita_late();
        test_reset_mid_filter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
